// File: rtl/stream_fetch_ctrl_if.sv
// rtl/stream_fetch_ctrl_if.sv - word-read port between the stream fetcher and stream memory
interface stream_fetch_ctrl_if;
  logic        mem_rd_en;
  logic        mem_rd_gnt;
  logic [29:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_gnt,
    input  mem_rd_valid,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_gnt,
    output mem_rd_valid,
    output mem_rd_data
  );
endinterface

// File: rtl/stream_fetch_ctrl.sv
// rtl/stream_fetch_ctrl.sv - credit-controlled word prefetch serving the NAL parser one byte at a time
module stream_fetch_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic [31:0]          base_addr,
  input  logic [LEN_W-1:0]     stream_len,
  input  logic                 run,
  input  logic                 byte_req,
  output logic                 dec_ena,
  output logic [7:0]           byte_data,
  stream_fetch_ctrl_if.master  mem,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PAD, S_DONE, S_DRAIN} state_t;

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count, outstanding, outs_nxt;
  logic [29:0]       word_ptr;
  logic [1:0]        byte_sel;
  logic [LEN_W-1:0]  bytes_left;
  logic [LEN_W:0]    words_left, words_calc;
  logic [1:0]        pad_cnt;
  logic [31:0]       head;
  logic              fifo_empty, issue, consume, push, pop;

  assign fifo_empty = (fifo_count == '0);
  assign head       = fifo_mem[rd_ptr];

  // Outstanding reads hold credit so a burst of returns can never overflow the FIFO.
  assign mem.mem_rd_en   = (state == S_FETCH) && (words_left != '0) &&
                           (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_V);
  assign mem.mem_rd_addr = word_ptr;

  assign issue    = mem.mem_rd_en && mem.mem_rd_gnt;
  assign outs_nxt = outstanding + CW'(issue) - CW'(mem.mem_rd_valid);
  assign push     = mem.mem_rd_valid && (state != S_DRAIN);
  assign consume  = byte_req && dec_ena;
  assign pop      = (state == S_FETCH) && consume &&
                    ((byte_sel == 2'd3) || (bytes_left == LEN_W'(1)));

  assign words_calc = ((LEN_W+1)'(base_addr[1:0]) + (LEN_W+1)'(stream_len) +
                       (LEN_W+1)'(3)) >> 2;

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  always_comb begin
    dec_ena   = 1'b0;
    byte_data = 8'h00;
    case (state)
      S_FETCH: begin
        dec_ena = run && !fifo_empty;
        if (!fifo_empty) begin
          case (byte_sel)
            2'd0:    byte_data = head[7:0];
            2'd1:    byte_data = head[15:8];
            2'd2:    byte_data = head[23:16];
            default: byte_data = head[31:24];
          endcase
        end
      end
      S_PAD: begin
        dec_ena   = run;
        byte_data = (pad_cnt == 2'd2) ? 8'h01 : 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[wr_ptr] <= mem.mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      word_ptr    <= '0;
      byte_sel    <= '0;
      bytes_left  <= '0;
      words_left  <= '0;
      pad_cnt     <= '0;
    end else begin
      outstanding <= outs_nxt;
      if (issue) begin
        word_ptr   <= word_ptr + 30'd1;
        words_left <= words_left - (LEN_W+1)'(1);
      end
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        pad_cnt    <= '0;
        bytes_left <= '0;
        state      <= (outs_nxt != '0) ? S_DRAIN : S_IDLE;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              word_ptr   <= base_addr[31:2];
              byte_sel   <= base_addr[1:0];
              bytes_left <= stream_len;
              words_left <= words_calc;
              pad_cnt    <= '0;
              state      <= (stream_len == '0) ? S_PAD : S_FETCH;
            end
          end
          S_FETCH: begin
            if (consume) begin
              bytes_left <= bytes_left - LEN_W'(1);
              byte_sel   <= byte_sel + 2'd1;
              if (bytes_left == LEN_W'(1)) begin
                pad_cnt <= '0;
                state   <= S_PAD;
              end
            end
          end
          S_PAD: begin
            if (consume) begin
              if (pad_cnt == 2'd2) state <= S_DONE;
              else                 pad_cnt <= pad_cnt + 2'd1;
            end
          end
          S_DRAIN: begin
            if (outs_nxt == '0) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_fetch_ctrl.sv
// tb/tb_stream_fetch_ctrl.sv - table-driven and directed scoreboard bench for stream_fetch_ctrl
module tb_stream_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, run, byte_req;
  logic [31:0] base_addr;
  logic [23:0] stream_len;
  logic        dec_ena, busy, done;
  logic [7:0]  byte_data;

  stream_fetch_ctrl_if mif();

  stream_fetch_ctrl #(.FIFO_DEPTH(8), .LEN_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
    .base_addr  (base_addr),
    .stream_len (stream_len),
    .run        (run),
    .byte_req   (byte_req),
    .dec_ena    (dec_ena),
    .byte_data  (byte_data),
    .mem        (mif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int base;
    int len;
    int lat;
    bit req_rand;
    int exp_reads;
  } case_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  case_t       cases[6];
  ret_t        pend[$];
  logic [7:0]  exp_bytes[$];
  logic [29:0] exp_addr[$];
  logic [31:0] img [int];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          grants = 0;
  int          consumed = 0;
  int          lat = 2;
  logic        gnt_allow = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    if (img.exists(a)) return img[a];
    return {8'(a * 7 + 3), 8'(a + 4), 8'(a * 3 + 1), 8'(a * 5 + 2)};
  endfunction

  // Expected bytes come from byte addresses, independent of how the DUT walks words.
  task automatic push_stream(input int base, input int len);
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = word_at((base + i) >> 2);
      exp_bytes.push_back(w[8 * ((base + i) & 3) +: 8]);
    end
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h01);
    if (len > 0)
      for (int wa = base >> 2; wa <= (base + len - 1) >> 2; wa++) exp_addr.push_back(30'(wa));
  endtask

  // One clock: present memory side, record grant/consume events, advance past the edge.
  task automatic step();
    mif.mem_rd_valid = 1'b0;
    mif.mem_rd_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mif.mem_rd_valid = 1'b1;
      mif.mem_rd_data  = pend[0].data;
      void'(pend.pop_front());
    end
    mif.mem_rd_gnt = gnt_allow;
    #1;
    if (mif.mem_rd_en && mif.mem_rd_gnt) begin
      grants++;
      if (exp_addr.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_addr: got %0h, no read expected", mif.mem_rd_addr);
      end else chk("read_addr", 64'(mif.mem_rd_addr), 64'(exp_addr.pop_front()));
      pend.push_back('{cyc + lat, word_at(int'(mif.mem_rd_addr))});
    end
    if (dec_ena && byte_req) begin
      consumed++;
      if (exp_bytes.size() == 0) begin
        checks++; errors++;
        $display("FAIL byte: got %0h, no byte expected", byte_data);
      end else chk("byte", 64'(byte_data), 64'(exp_bytes.pop_front()));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(input bit req_rand, input int g0, input int exp_reads);
    for (int k = 0; k < 3000 && !done; k++) begin
      if (req_rand) byte_req = 1'($urandom_range(0, 1));
      step();
    end
    chk("done", 64'(done), 64'(1));
    chk("dec_ena_after_done", 64'(dec_ena), 64'(0));
    chk("read_count", 64'(grants - g0), 64'(exp_reads));
    chk("bytes_remaining", 64'(exp_bytes.size()), 64'(0));
    byte_req = 1'b1;
  endtask

  task automatic run_case(input case_t t);
    int g0;
    lat = t.lat;
    push_stream(t.base, t.len);
    base_addr  = 32'(t.base);
    stream_len = 24'(t.len);
    byte_req   = 1'b1;
    start      = 1'b1;
    g0         = grants;
    step();
    start = 1'b0;
    wait_done(t.req_rand, g0, t.exp_reads);
  endtask

  initial begin
    int g0;
    img[32'h40] = 32'h0100_0000;
    img[32'h41] = 32'h0967_0000;
    cases[0] = '{32'h100, 8,  2, 1'b0, 2};
    cases[1] = '{32'h103, 2,  2, 1'b0, 2};
    cases[2] = '{32'h201, 13, 5, 1'b0, 4};
    cases[3] = '{32'h302, 1,  1, 1'b0, 1};
    cases[4] = '{32'h400, 0,  2, 1'b0, 0};
    cases[5] = '{32'h503, 40, 3, 1'b1, 11};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; run = 1'b1; byte_req = 1'b0;
    base_addr = '0; stream_len = '0;
    mif.mem_rd_gnt = 1'b0; mif.mem_rd_valid = 1'b0; mif.mem_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_ena", 64'(dec_ena), 64'(0));
    chk("rst_rd_en", 64'(mif.mem_rd_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_byte_data", 64'(byte_data), 64'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_case(cases[i]);

    // Zero-length stream presents the pad bytes on the cycle right after start.
    lat = 2; push_stream(32'h10, 0);
    base_addr = 32'h10; stream_len = 24'd0; byte_req = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    chk("len0_dec_ena", 64'(dec_ena), 64'(1));
    chk("len0_byte0", 64'(byte_data), 64'(0));
    byte_req = 1'b1; g0 = grants;
    wait_done(1'b0, g0, 0);

    // Credit backpressure: FIFO plus in-flight reads cap at 8 words.
    lat = 2; push_stream(32'h0, 64);
    base_addr = 32'h0; stream_len = 24'd64; byte_req = 1'b0; start = 1'b1; g0 = grants;
    step(); start = 1'b0;
    repeat (30) step();
    chk("credit_grants", 64'(grants - g0), 64'(8));
    chk("credit_rd_en", 64'(mif.mem_rd_en), 64'(0));
    consumed = 0; byte_req = 1'b1;
    for (int k = 0; k < 50 && consumed < 4; k++) step();
    byte_req = 1'b0;
    repeat (10) step();
    chk("credit_one_more", 64'(grants - g0), 64'(9));
    chk("credit_rd_en2", 64'(mif.mem_rd_en), 64'(0));
    flush = 1'b1; step(); flush = 1'b0;
    exp_bytes.delete(); exp_addr.delete();
    chk("credit_flush_idle", 64'(busy), 64'(0));

    // Memory stall: request held with a stable address; a start in FETCH is ignored.
    lat = 2; push_stream(32'h600, 8);
    base_addr = 32'h600; stream_len = 24'd8; byte_req = 1'b1; gnt_allow = 1'b0;
    start = 1'b1; g0 = grants;
    step(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_rd_en", 64'(mif.mem_rd_en), 64'(1));
      chk("stall_addr", 64'(mif.mem_rd_addr), 64'(30'h180));
      chk("stall_dec_ena", 64'(dec_ena), 64'(0));
      if (k == 2) begin base_addr = 32'h900; stream_len = 24'd3; start = 1'b1; end
      step();
      start = 1'b0;
    end
    gnt_allow = 1'b1;
    wait_done(1'b0, g0, 2);

    // Flush with three reads in flight: DRAIN until the third return, data never shown.
    lat = 12; push_stream(32'h700, 64);
    base_addr = 32'h700; stream_len = 24'd64; byte_req = 1'b0; start = 1'b1; g0 = grants;
    step(); start = 1'b0;
    for (int k = 0; k < 20 && (grants - g0) < 3; k++) step();
    gnt_allow = 1'b0;
    chk("flush_outstanding", 64'(pend.size()), 64'(3));
    flush = 1'b1; step(); flush = 1'b0;
    exp_bytes.delete(); exp_addr.delete();
    gnt_allow = 1'b1; byte_req = 1'b1;
    chk("drain_busy", 64'(busy), 64'(1));
    chk("drain_rd_en", 64'(mif.mem_rd_en), 64'(0));
    chk("drain_dec_ena", 64'(dec_ena), 64'(0));
    for (int k = 0; k < 30; k++) begin
      step();
      if (pend.size() == 0) begin
        chk("drain_to_idle", 64'(busy), 64'(0));
        break;
      end
      chk("drain_hold", 64'(busy), 64'(1));
    end
    chk("drain_returns_done", 64'(pend.size()), 64'(0));

    run_case(cases[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fetch_ctrl.md
Name: stream_fetch_ctrl

Overview:
- Feeds the NAL-unit byte parser from word-wide stream memory.
- Fetches 32-bit words into a credit-controlled prefetch FIFO and serves them one byte at a time on the parser's byte request.
- Stalls the parser through its enable when no byte is available.
- At end of stream, appends a synthetic 00 00 01 start code so the final NAL unit is flushed.
- Sits between the stream memory port and the NAL parser; sequenced by the top-level decoder control.

Parameters:
- FIFO_DEPTH, 8, prefetch FIFO depth in 32-bit words; power of two, at least 2.
- LEN_W, 24, width of the stream byte-length field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr and stream_len and begins a stream.
- flush  in  1  one-cycle pulse; aborts the current stream.
- base_addr  in  32  byte address of the first stream byte; may be unaligned.
- stream_len  in  LEN_W  stream length in bytes.
- run  in  1  global decoder enable.
- byte_req  in  1  byte-consume request from the parser; counts only when dec_ena=1.
- dec_ena  out  1  enable to the parser; high only when a byte is presentable.
- byte_data  out  8  current byte to the parser; combinational from FIFO head or pad counter.
- mem_rd_en  out  1  word read request; held until granted.
- mem_rd_gnt  in  1  memory accepts the request this cycle.
- mem_rd_addr  out  30  word address.
- mem_rd_valid  in  1  read data return; in order, arbitrary latency.
- mem_rd_data  in  32  returned word; byte at lowest address is in [7:0].
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset: state IDLE. All outputs 0, FIFO empty, all counters 0.
- States: IDLE, FETCH, PAD, DONE, DRAIN.
- IDLE/DONE + start:
  - Latch word_ptr = base_addr[31:2] and byte_sel = base_addr[1:0].
  - bytes_left = stream_len.
  - words_left = (base_addr[1:0] + stream_len + 3) >> 2, computed at LEN_W+1 bits.
  - Go to FETCH, or to PAD if stream_len = 0.
  - start is ignored in FETCH, PAD and DRAIN.
- Issue rule:
  - mem_rd_en = (state FETCH) and words_left > 0 and (fifo_count + outstanding) < FIFO_DEPTH.
  - mem_rd_addr = word_ptr.
  - On en && gnt: word_ptr+1, words_left-1, outstanding+1.
  - FIFO overflow is therefore impossible.
- Return: mem_rd_valid pushes the word and decrements outstanding. In DRAIN the data is discarded; outstanding still decrements.
- dec_ena:
  - FETCH: run && fifo not empty.
  - PAD: run.
  - All other states: 0.
- Consume = byte_req && dec_ena.
- FETCH consume:
  - byte_data = head[8*byte_sel+7 : 8*byte_sel].
  - bytes_left-1, byte_sel+1 (wraps 3 to 0).
  - Pop the head when byte_sel = 3 or bytes_left = 1.
  - When bytes_left becomes 0, go to PAD with pad_cnt = 0.
- PAD: byte_data = 00, 00, 01 for pad_cnt = 0, 1, 2. Each consume increments pad_cnt. Consume at pad_cnt = 2 goes to DONE.
- Push and pop in the same cycle: fifo_count unchanged.
- flush:
  - Empties the FIFO and clears pad_cnt and bytes_left.
  - Goes to DRAIN if outstanding > 0, else IDLE.
  - flush beats start in the same cycle.
  - flush in IDLE or DONE goes to IDLE.
- DRAIN: mem_rd_en = 0. Go to IDLE when outstanding reaches 0, including the cycle its last return arrives.
- Reset mid-operation: immediate return to reset values. Late memory returns after reset are the memory side's responsibility.

Test Plan:
- Aligned stream, no stall: base 0x100, len 8, words 0x01000000 and 0x09670000 returned with 2-cycle latency, byte_req=1, run=1.
  - Required: word reads 0x40 and 0x41 only.
  - Required byte sequence: 00 00 00 01 00 00 67 09 00 00 01; then done=1 and dec_ena=0.
- Unaligned start: base 0x103, len 2.
  - Required: reads 0x40 and 0x41.
  - Required bytes: word0[31:24], then word1[7:0], then pad 00 00 01.
- Credit backpressure: FIFO_DEPTH 8, len 64, byte_req=0.
  - Required: exactly 8 grants, then mem_rd_en=0.
  - Required: one consumed word (4 bytes) re-enables exactly one issue.
- Memory stall: gnt=0 for 5 cycles.
  - Required: mem_rd_en held with a stable address.
  - Required: dec_ena=0 while the FIFO is empty; no byte is consumed.
- flush with 3 outstanding reads.
  - Required: state DRAIN and mem_rd_en=0.
  - Required: IDLE in the cycle the third return arrives; returned data is never presented.
- len 0 with start: required bytes 00 00 01 immediately, then done. A start pulse in FETCH leaves bytes_left unchanged.
